fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning fetch address loaded on reset.
REQ-002 SHALL have parameter QDEPTH, default 4, meaning fetch-queue depth in entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fetch_pc_o  output  32  byte address presented to instruction memory; memory returns words at fetch_pc_o and fetch_pc_o+4 combinationally.
REQ-006 SHALL have port instr_i  input  2x32  fetched pair; [0] = word at fetch_pc_o, [1] = next word.
REQ-007 SHALL have port redirect_valid_i  input  1  branch/jump/trap redirect request.
REQ-008 SHALL have port redirect_pc_i  input  32  redirect target.
REQ-009 SHALL have port dec_valid_o  output  1  head queue entry is valid for decode.
REQ-010 SHALL have port dec_instr_o  output  2x32  head entry instruction pair.
REQ-011 SHALL have port dec_pc_o  output  32  PC of dec_instr_o[0]; slot 1 PC is dec_pc_o+4.
REQ-012 SHALL have port dec_ready_i  input  1  decode accepts head entry when dec_valid_o=1.
REQ-013 SHALL have port misalign_o  output  1  sticky flag: misaligned redirect target.
REQ-014 SHALL have port misalign_pc_o  output  32  offending redirect target.
REQ-015 SHALL have port stall_cycles_o  output  16  saturating count of queue-full fetch stalls.

Function
REQ-016 SHALL implement states IDLE, RUN, ERR; IDLE lasts exactly one cycle after reset deassertion, then RUN; no enqueue in IDLE.
REQ-017 In RUN, SHALL enqueue {fetch_pc_o, instr_i} when queue not full, or full with a pop in the same cycle, and advance fetch_pc_o by 8 (modulo 2^32, 32'hFFFF_FFF8 wraps to 0).
REQ-018 In RUN with queue full and no pop, SHALL hold fetch_pc_o, not enqueue, and increment stall_cycles_o, saturating at 16'hFFFF.
REQ-019 SHALL pop the head when dec_valid_o && dec_ready_i; dec_valid_o = (count != 0); dec_* outputs driven from registered queue storage, no combinational path from instr_i.
REQ-020 Enqueue-to-dec_valid_o latency SHALL be one cycle; empty queue never bypasses.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo QDEPTH.
REQ-022 redirect_valid_i SHALL have priority in every state: queue cleared (count=0, pointers=0) at that edge, same-cycle push and pop voided, decode must discard the head shown that cycle.
REQ-023 Aligned redirect (redirect_pc_i[1:0]==0) SHALL load fetch_pc_o <= redirect_pc_i and enter RUN, including from IDLE and ERR; redirect_pc_i[2]=1 is legal.
REQ-024 Misaligned redirect SHALL set misalign_o=1, capture misalign_pc_o, keep fetch_pc_o, enter ERR; ERR performs no fetch, no enqueue, no stall count.
REQ-025 misalign_o SHALL clear only on reset or an aligned redirect.

Reset
REQ-026 On rst assertion, asynchronously: state=IDLE, fetch_pc_o=RESET_PC, count/pointers=0, dec_valid_o=0, misalign_o=0, misalign_pc_o=0, stall_cycles_o=0.
REQ-027 Reset mid-operation SHALL discard all queue contents and pending redirect; queue data storage needs no reset.

Structure
REQ-028 Package fetch_pkg SHALL hold fetch_state_e, fetch_entry_t (pc 32, instr 2x32), and INSTR_W=32 and FETCH_W=2.
REQ-029 Queue SHALL be sub-module fetch_queue (parameterised FIFO of fetch_entry_t with push, pop, clear, full, empty); controller holds FSM, PC, counter.

Verification
REQ-030 Reset then 6 cycles with dec_ready_i=1 -> fetch_pc_o 0,0,8,16,24..., first dec_valid_o at cycle 2 with dec_pc_o=0.
REQ-031 dec_ready_i=0 for 10 cycles, QDEPTH=4 -> 4 entries, fetch_pc_o holds 32, stall_cycles_o=5; ready=1 -> entries drain in PC order 0,8,16,24.
REQ-032 Queue holding 3 entries, redirect to 32'h0000_0104 -> next cycle dec_valid_o=0, fetch_pc_o=32'h104; following cycle dec_pc_o=32'h104.
REQ-033 Redirect to 32'h0000_0102 -> misalign_o=1, misalign_pc_o=32'h102, no enqueue for 5 cycles; redirect 32'h200 -> misalign_o=0, fetch resumes at 32'h200.
REQ-034 Redirect to 32'hFFFF_FFF8 -> entries PC FFFF_FFF8 then 0000_0000; rst asserted mid-drain -> dec_valid_o=0 immediately, fetch_pc_o=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FETCH_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]                    pc;
        logic [FETCH_W-1:0][INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO of fetch entries; clear has priority over push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/fetch_controller.sv
// Fetch FSM: walks the PC in 8-byte pairs into a decode queue, honours redirects.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [31:0]                    fetch_pc_o,
    input  logic [FETCH_W-1:0][INSTR_W-1:0] instr_i,
    input  logic                           redirect_valid_i,
    input  logic [31:0]                    redirect_pc_i,
    output logic                           dec_valid_o,
    output logic [FETCH_W-1:0][INSTR_W-1:0] dec_instr_o,
    output logic [31:0]                    dec_pc_o,
    input  logic                           dec_ready_i,
    output logic                           misalign_o,
    output logic [31:0]                    misalign_pc_o,
    output logic [15:0]                    stall_cycles_o
);

    fetch_state_e state;
    fetch_entry_t enq_entry;
    fetch_entry_t head;
    logic         full;
    logic         empty;
    logic         pop;
    logic         push;

    // Redirect voids both queue operations for the cycle it is seen.
    assign pop  = !empty && dec_ready_i && !redirect_valid_i;
    assign push = (state == RUN) && !redirect_valid_i && (!full || pop);

    assign enq_entry.pc    = fetch_pc_o;
    assign enq_entry.instr = instr_i;

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .clear(redirect_valid_i),
        .din  (enq_entry),
        .head (head),
        .full (full),
        .empty(empty)
    );

    assign dec_valid_o = !empty;
    assign dec_pc_o    = head.pc;
    assign dec_instr_o = head.instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            fetch_pc_o     <= RESET_PC;
            misalign_o     <= 1'b0;
            misalign_pc_o  <= '0;
            stall_cycles_o <= '0;
        end else if (redirect_valid_i) begin
            if (redirect_pc_i[1:0] == 2'b00) begin
                fetch_pc_o <= redirect_pc_i;
                misalign_o <= 1'b0;
                state      <= RUN;
            end else begin
                misalign_o    <= 1'b1;
                misalign_pc_o <= redirect_pc_i;
                state         <= ERR;
            end
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (push)
                        fetch_pc_o <= fetch_pc_o + 32'd8;
                    else if (stall_cycles_o != '1)
                        stall_cycles_o <= stall_cycles_o + 16'd1;
                end
                default: state <= state;
            endcase
        end
    end

endmodule
